flags_ctx_stack: RTL

Hardware shadow stack for the condition-code register (CCR) that saves and returns flags around interrupt entry and return. It sits between the control unit and the flags register. On interrupt entry it captures `flags_out` (push). On RTI it pops the saved value and drives the flags register's restore port for exactly one cycle. This makes it the producer of `restore_flags` / `restore_flags_value`.

---
 rtl/flags_pkg.sv | 18 +
 rtl/flags_lifo_ram.sv | 27 ++
 rtl/flags_ctx_stack.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/flags_pkg.sv
// Shared CCR definitions: flag bit positions, register width and the
// context-stack FSM state encoding.
package flags_pkg;

  localparam int unsigned CCR_WIDTH = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPopRd   = 2'd1,
    StRestore = 2'd2
  } ctx_state_e;

endpackage

// File: rtl/flags_lifo_ram.sv
// Storage array for saved CCR values: synchronous write, registered read,
// contents deliberately left unreset.
module flags_lifo_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/flags_ctx_stack.sv
// Shadow stack for the CCR across interrupt entry (push) and RTI (pop).
// Sticky overflow/underflow flags are built only when FLAGS_CTX_ERR_EN is defined.
module flags_ctx_stack
  import flags_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = CCR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       flags_in,
  output logic                   restore_flags,
  output logic [WIDTH-1:0]       restore_flags_value,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = AW + 1;

  ctx_state_e       state_q, state_d;
  logic [SW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             we, re;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rdata;
  logic             ovf_set, unf_set;

  assign full  = (sp_q == SW'(DEPTH));
  assign empty = (sp_q == '0);
  assign level = sp_q;

  assign waddr = sp_q[AW-1:0];
  assign raddr = AW'(sp_q - SW'(1));

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    value_d = value_q;
    we      = 1'b0;
    re      = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Push has priority; a simultaneous pop is dropped silently.
        if (push) begin
          if (!full) begin
            we   = 1'b1;
            sp_d = sp_q + SW'(1);
          end else begin
            ovf_set = 1'b1;
          end
        end else if (pop) begin
          if (!empty) begin
            re      = 1'b1;
            sp_d    = sp_q - SW'(1);
            state_d = StPopRd;
          end else begin
            unf_set = 1'b1;
          end
        end
      end
      StPopRd: begin
        value_d = rdata;
        state_d = StRestore;
      end
      StRestore: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sp_q    <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      value_q <= value_d;
    end
  end

  assign busy                = (state_q != StIdle);
  assign restore_flags       = (state_q == StRestore);
  assign restore_flags_value = value_q;

`ifdef FLAGS_CTX_ERR_EN
  logic ovf_q, unf_q;

  // A new error event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clr_err) begin
        ovf_q <= 1'b0;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end else if (clr_err) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_err;
  assign unused_err = clr_err ^ ovf_set ^ unf_set;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

  flags_lifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (flags_in),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule
